axi_lite_display_bank: RTL and testbench

- Multi-channel AXI-lite memory-mapped display register bank for the SoC debug/display path.
- Holds NUM_CH display words, each DATA_WIDTH wide, writable with byte strobes and readable back over AXI-lite.
- Drives the board displayer, with one flattened display word per channel and a one-cycle update pulse per channel.
- Generalises the single-word displayer to N channels, byte-strobed writes, address-error responses and readback.

---
 rtl/axi_lite_display_bank.sv | 267 ++++++++++++++++++++++++++
 tb/tb_axi_lite_display_bank.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_display_bank.sv
// AXI-lite bank of NUM_CH display words with byte-strobed writes, readback and per-channel update pulses; optional DISPLAY_COSIM_EN adds a commit trace port.
// Latency: bvalid/rvalid one cycle after the completing AW+W / AR handshake; display_o and update_o change on the write commit edge.
// Backpressure: one outstanding transaction per direction; readies stay low until bready/rready completes the response.
module axi_lite_display_bank #(
    parameter int                     DATA_WIDTH = 64,
    parameter int                     ADDR_WIDTH = 64,
    parameter int                     NUM_CH     = 4,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_CH*DATA_WIDTH-1:0]   display_o,
    output logic [NUM_CH-1:0]              update_o
`ifdef DISPLAY_COSIM_EN
    ,
    output logic                           cosim_valid,
    output logic [ADDR_WIDTH-1:0]          cosim_addr,
    output logic [DATA_WIDTH-1:0]          cosim_data,
    output logic                           cosim_is_store
`endif
);

    localparam int BPW  = DATA_WIDTH / 8;
    localparam int BSH  = $clog2(BPW);
    localparam int IDXW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_CH * BPW);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return off < SPAN;
    endfunction

    // Truncating the shifted offset yields the channel index for power-of-2 NUM_CH.
    function automatic logic [IDXW-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = (a - BASE_ADDR) >> BSH;
        return off[IDXW-1:0];
    endfunction

    w_state_e                w_state_q, w_state_d;
    r_state_e                r_state_q, r_state_d;
    logic                    aw_lat_q, aw_lat_d;
    logic                    w_lat_q, w_lat_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BPW-1:0]          wstrb_q, wstrb_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [NUM_CH-1:0]       upd_q, upd_d;
    logic [DATA_WIDTH-1:0]   ch_q [NUM_CH];
    logic [DATA_WIDTH-1:0]   ch_d [NUM_CH];
    logic                    rvalid_q, rvalid_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                    aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [BPW-1:0]          w_strb;
    logic                    w_ok, r_ok;
    logic [IDXW-1:0]         w_idx, r_idx;
    logic [DATA_WIDTH-1:0]   w_merged;

    assign awready = (w_state_q == W_IDLE) && !aw_lat_q;
    assign wready  = (w_state_q == W_IDLE) && !w_lat_q;
    assign arready = (r_state_q == R_IDLE);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;

    // A half that arrives this cycle is used directly so the commit lands on its handshake edge.
    assign w_addr  = aw_lat_q ? awaddr_q : awaddr;
    assign w_data  = w_lat_q  ? wdata_q  : wdata;
    assign w_strb  = w_lat_q  ? wstrb_q  : wstrb;
    assign commit  = (aw_lat_q || aw_hs) && (w_lat_q || w_hs);
    assign w_ok    = addr_in_range(w_addr);
    assign w_idx   = addr_index(w_addr);
    assign r_ok    = addr_in_range(araddr);
    assign r_idx   = addr_index(araddr);

    always_comb begin
        w_merged = ch_q[w_idx];
        for (int j = 0; j < BPW; j++) begin
            if (w_strb[j]) begin
                w_merged[j*8 +: 8] = w_data[j*8 +: 8];
            end
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        aw_lat_d  = aw_lat_q;
        w_lat_d   = w_lat_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        upd_d     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_d[i] = ch_q[i];
        end
        if (w_state_q == W_IDLE) begin
            if (commit) begin
                aw_lat_d  = 1'b0;
                w_lat_d   = 1'b0;
                bvalid_d  = 1'b1;
                bresp_d   = w_ok ? RESP_OKAY : RESP_SLVERR;
                w_state_d = W_RESP;
                if (w_ok) begin
                    ch_d[w_idx]  = w_merged;
                    upd_d[w_idx] = 1'b1;
                end
            end else begin
                if (aw_hs) begin
                    aw_lat_d = 1'b1;
                    awaddr_d = awaddr;
                end
                if (w_hs) begin
                    w_lat_d = 1'b1;
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                end
            end
        end else if (bready) begin
            bvalid_d  = 1'b0;
            w_state_d = W_IDLE;
        end
    end

    // Reads sample ch_q, so a same-edge write commit is not visible to them.
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        if (r_state_q == R_IDLE) begin
            if (ar_hs) begin
                rvalid_d  = 1'b1;
                rresp_d   = r_ok ? RESP_OKAY : RESP_SLVERR;
                rdata_d   = r_ok ? ch_q[r_idx] : '0;
                r_state_d = R_DATA;
            end
        end else if (rready) begin
            rvalid_d  = 1'b0;
            r_state_d = R_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_lat_q  <= 1'b0;
            w_lat_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            upd_q     <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_lat_q  <= aw_lat_d;
            w_lat_q   <= w_lat_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            upd_q     <= upd_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_q[i] <= ch_d[i];
            end
        end
    end

    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign rvalid   = rvalid_q;
    assign rresp    = rresp_q;
    assign rdata    = rdata_q;
    assign update_o = upd_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_disp
        assign display_o[i*DATA_WIDTH +: DATA_WIDTH] = ch_q[i];
    end

`ifdef DISPLAY_COSIM_EN
    logic                   cv_q, cv_d;
    logic                   cst_q, cst_d;
    logic [ADDR_WIDTH-1:0]  ca_q, ca_d;
    logic [DATA_WIDTH-1:0]  cd_q, cd_d;

    // A single trace slot: a write commit wins over a read issued on the same edge.
    always_comb begin
        cv_d  = 1'b0;
        cst_d = cst_q;
        ca_d  = ca_q;
        cd_d  = cd_q;
        if (commit) begin
            cv_d  = 1'b1;
            cst_d = 1'b1;
            ca_d  = w_addr;
            cd_d  = w_ok ? w_merged : w_data;
        end else if (ar_hs) begin
            cv_d  = 1'b1;
            cst_d = 1'b0;
            ca_d  = araddr;
            cd_d  = rdata_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cv_q  <= 1'b0;
            cst_q <= 1'b0;
            ca_q  <= '0;
            cd_q  <= '0;
        end else begin
            cv_q  <= cv_d;
            cst_q <= cst_d;
            ca_q  <= ca_d;
            cd_q  <= cd_d;
        end
    end

    assign cosim_valid    = cv_q;
    assign cosim_is_store = cst_q;
    assign cosim_addr     = ca_q;
    assign cosim_data     = cd_q;
`endif

endmodule

// File: tb/tb_axi_lite_display_bank.sv
// Directed bench for axi_lite_display_bank at default parameters (64-bit data, 4 channels, base 0).
module tb_axi_lite_display_bank;

    logic          clk = 1'b0;
    logic          rstn;
    logic [63:0]   awaddr, wdata, araddr, rdata;
    logic          awvalid, awready, wvalid, wready;
    logic [7:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          bvalid, bready, arvalid, arready, rvalid, rready;
    logic [255:0]  display_o;
    logic [3:0]    update_o;

    int checks   = 0;
    int failures = 0;

    logic [1:0]    resp;
    logic [3:0]    upd;
    logic [63:0]   rd;
    int            lat;

    axi_lite_display_bank dut (
        .clk(clk), .rstn(rstn),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .display_o(display_o), .update_o(update_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one write with both channels presented together; reports bresp, update_o and cycles to bvalid.
    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                            output logic [1:0] r, output logic [3:0] u, output int l);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        r = 2'bxx; u = 4'bxxxx; l = 0;
        for (int c = 0; c < 20; c++) begin
            logic aw_done, w_done;
            aw_done = awvalid && awready;
            w_done  = wvalid && wready;
            step();
            l++;
            if (aw_done) awvalid = 1'b0;
            if (w_done)  wvalid  = 1'b0;
            if (bvalid) begin
                r = bresp;
                u = update_o;
                break;
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] a, output logic [63:0] d, output logic [1:0] r);
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        d = 64'hx; r = 2'bxx;
        for (int c = 0; c < 20; c++) begin
            logic ar_done;
            ar_done = arvalid && arready;
            step();
            if (ar_done) arvalid = 1'b0;
            if (rvalid) begin
                d = rdata;
                r = rresp;
                break;
            end
        end
        arvalid = 1'b0;
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        step(); step();
        checks++;
        if (display_o !== 256'h0) begin failures++; $display("FAIL reset_display got=%h exp=0", display_o); end
        checks++;
        if ({update_o, bvalid, rvalid, bresp, rresp} !== 10'h0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0", {update_o, bvalid, rvalid, bresp, rresp});
        end
        checks++;
        if (rdata !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            failures++; $display("FAIL reset_ready got=%b exp=111", {awready, wready, arready});
        end
        #3 rstn = 1'b1;
        step();
    endtask

    task automatic test_single_write();
        do_write(64'h10, 64'h1122334455667788, 8'hFF, resp, upd, lat);
        checks++;
        if (resp !== 2'b00) begin failures++; $display("FAIL w1_bresp got=%b exp=00", resp); end
        checks++;
        if (upd !== 4'b0100) begin failures++; $display("FAIL w1_update got=%b exp=0100", upd); end
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL w1_latency got=%0d exp=1", lat); end
        checks++;
        if (display_o[191:128] !== 64'h1122334455667788) begin
            failures++; $display("FAIL w1_display got=%h exp=1122334455667788", display_o[191:128]);
        end
        checks++;
        if ({bvalid, update_o} !== 5'b0) begin
            failures++; $display("FAIL w1_after_b got=%b exp=00000", {bvalid, update_o});
        end
    endtask

    task automatic test_partial_strobe();
        do_write(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, resp, upd, lat);
        do_write(64'h0, 64'h0, 8'h0F, resp, upd, lat);
        checks++;
        if (display_o[63:0] !== 64'hFFFF_FFFF_0000_0000) begin
            failures++; $display("FAIL strobe_display got=%h exp=ffffffff00000000", display_o[63:0]);
        end
        do_read(64'h0, rd, resp);
        checks++;
        if (rd !== 64'hFFFF_FFFF_0000_0000 || resp !== 2'b00) begin
            failures++; $display("FAIL strobe_readback got=%h/%b exp=ffffffff00000000/00", rd, resp);
        end
        do_write(64'h0, 64'h0123_4567_89AB_CDEF, 8'h00, resp, upd, lat);
        checks++;
        if (display_o[63:0] !== 64'hFFFF_FFFF_0000_0000 || upd !== 4'b0001 || resp !== 2'b00) begin
            failures++; $display("FAIL zero_strobe got=%h/%b/%b exp=ffffffff00000000/0001/00", display_o[63:0], upd, resp);
        end
    endtask

    task automatic test_split_aw_w();
        awaddr = 64'h18; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
        step();
        awvalid = 1'b0;
        checks++;
        if ({awready, wready, bvalid} !== 3'b010 || display_o[255:192] !== 64'h0) begin
            failures++; $display("FAIL split_aw_only got=%b/%h exp=010/0", {awready, wready, bvalid}, display_o[255:192]);
        end
        step(); step();
        wdata = 64'hA5A5_A5A5_A5A5_A5A5; wstrb = 8'hFF; wvalid = 1'b1;
        checks++;
        if (bvalid !== 1'b0 || display_o[255:192] !== 64'h0) begin
            failures++; $display("FAIL split_wait got=%b/%h exp=0/0", bvalid, display_o[255:192]);
        end
        step();
        wvalid = 1'b0;
        checks++;
        if ({bvalid, update_o} !== 5'b11000 || display_o[255:192] !== 64'hA5A5_A5A5_A5A5_A5A5) begin
            failures++; $display("FAIL split_commit got=%b/%h exp=11000/a5a5a5a5a5a5a5a5", {bvalid, update_o}, display_o[255:192]);
        end
        awaddr = 64'h18; wdata = 64'h1; awvalid = 1'b1; wvalid = 1'b1;
        step(); step();
        checks++;
        if ({bvalid, awready, wready, update_o} !== 7'b1000000 || display_o[255:192] !== 64'hA5A5_A5A5_A5A5_A5A5) begin
            failures++; $display("FAIL split_hold got=%b/%h exp=1000000/a5a5a5a5a5a5a5a5", {bvalid, awready, wready, update_o}, display_o[255:192]);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        step();
        bready = 1'b0;
        checks++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            failures++; $display("FAIL split_release got=%b exp=011", {bvalid, awready, wready});
        end
    endtask

    task automatic test_out_of_range();
        do_write(64'h20, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, resp, upd, lat);
        checks++;
        if (resp !== 2'b10 || upd !== 4'b0000) begin
            failures++; $display("FAIL oor_write got=%b/%b exp=10/0000", resp, upd);
        end
        checks++;
        if (display_o !== {64'hA5A5_A5A5_A5A5_A5A5, 64'h1122334455667788, 64'h0, 64'hFFFF_FFFF_0000_0000}) begin
            failures++; $display("FAIL oor_display got=%h", display_o);
        end
        do_read(64'h20, rd, resp);
        checks++;
        if (rd !== 64'h0 || resp !== 2'b10) begin
            failures++; $display("FAIL oor_read got=%h/%b exp=0/10", rd, resp);
        end
        do_read(64'h13, rd, resp);
        checks++;
        if (rd !== 64'h1122334455667788 || resp !== 2'b00) begin
            failures++; $display("FAIL read_ch2 got=%h/%b exp=1122334455667788/00", rd, resp);
        end
    endtask

    task automatic test_same_edge();
        do_write(64'h08, 64'h5, 8'hFF, resp, upd, lat);
        awaddr = 64'h08; wdata = 64'h9; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 64'h08; arvalid = 1'b1; bready = 1'b1; rready = 1'b0;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 64'h5) begin
            failures++; $display("FAIL same_edge_old got=%b/%h exp=1/5", rvalid, rdata);
        end
        checks++;
        if (display_o[127:64] !== 64'h9 || update_o !== 4'b0010) begin
            failures++; $display("FAIL same_edge_commit got=%h/%b exp=9/0010", display_o[127:64], update_o);
        end
        rready = 1'b1;
        step();
        rready = 1'b0; bready = 1'b0;
        do_read(64'h08, rd, resp);
        checks++;
        if (rd !== 64'h9 || resp !== 2'b00) begin
            failures++; $display("FAIL same_edge_new got=%h/%b exp=9/00", rd, resp);
        end
    endtask

    task automatic test_reset_mid();
        awaddr = 64'h0; wdata = 64'h77; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 64'h0; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        checks++;
        if ({bvalid, rvalid} !== 2'b11 || display_o[63:0] !== 64'h77) begin
            failures++; $display("FAIL mid_setup got=%b/%h exp=11/77", {bvalid, rvalid}, display_o[63:0]);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({bvalid, rvalid} !== 2'b00 || display_o !== 256'h0) begin
            failures++; $display("FAIL mid_async got=%b/%h exp=00/0", {bvalid, rvalid}, display_o);
        end
        #2 rstn = 1'b1;
        step();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, update_o} !== 9'b111000000) begin
            failures++; $display("FAIL mid_release got=%b exp=111000000", {awready, wready, arready, bvalid, rvalid, update_o});
        end
    endtask

    task automatic test_back_to_back();
        awaddr = 64'h0; wdata = 64'hAAAA; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        step();
        checks++;
        if (bvalid !== 1'b1 || display_o[63:0] !== 64'hAAAA) begin
            failures++; $display("FAIL b2b_first got=%b/%h exp=1/aaaa", bvalid, display_o[63:0]);
        end
        awaddr = 64'h08; wdata = 64'hBBBB;
        step();
        checks++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            failures++; $display("FAIL b2b_gap got=%b exp=011", {bvalid, awready, wready});
        end
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || display_o[127:0] !== {64'hBBBB, 64'hAAAA} || update_o !== 4'b0010) begin
            failures++; $display("FAIL b2b_second got=%b/%h/%b exp=1/bbbb_aaaa/0010", bvalid, display_o[127:0], update_o);
        end
        step();
        bready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_partial_strobe();
        test_split_aw_w();
        test_out_of_range();
        test_same_edge();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
